rx_sample_packer: RTL and testbench
===================================

# rx_sample_packer

Upstream feeder for `rx_buffer`, running in the `rx_clk` domain. On each `rxstrobe` it captures the enabled 16-bit channel samples `ch_0`..`ch_3`. It serializes them into a continuous stream of 16-bit half-words and packs consecutive pairs into 32-bit words, which it writes into the write port of the rx FIFO. It tracks lost data caused by a full FIFO or strobes arriving too fast, using a sticky overrun flag and a saturating drop counter.

## Interface
- No parameters.
- `rx_clk` in 1: sole clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `clear_status` in 1: synchronous clear of `rx_overrun` and `dropped_words`.
- `channels` in 4: channel enable mask, bit i enables `ch_i`; sampled only on an accepted strobe.
- `ch_0`, `ch_1`, `ch_2`, `ch_3` in 16 each: channel samples, valid in the cycle `rxstrobe` is high.
- `rxstrobe` in 1: one-cycle sample-valid pulse.
- `fifo_full` in 1: rx FIFO write-side full flag (`wrfull`).
- `fifo_data` out 32: word to FIFO; bits [15:0] hold the earlier half-word, bits [31:16] the later.
- `fifo_wrreq` out 1: one-cycle write request for `fifo_data`.
- `rx_overrun` out 1: sticky loss flag.
- `dropped_words` out 16: count of lost words and strobes, saturating at 16'hFFFF.
- `debug_bus` out 16: {`pending[3:0]`, `half_valid`, `fifo_wrreq`, `fifo_full`, `rx_overrun`, `dropped_words[7:0]`}.

## Operation
**Registers**
- `hold0..3`: 16-bit sample holding registers.
- `pending[3:0]`: channels still to emit.
- `acc_lo[15:0]` and `half_valid`: half-word accumulator.

**Strobe acceptance**
- A strobe is accepted when `rxstrobe`=1, `channels`≠0, and either `pending`==0 or `pending` has exactly one bit set (its last channel is consumed on this same edge).
- On acceptance: `hold0..3` ← `ch_0..3` and `pending` ← `channels`.
- `rxstrobe` with `channels`==0 is ignored. It causes no error.
- `rxstrobe` while `pending` has two or more bits set is rejected:
  - the samples are discarded and `pending` and the hold registers are unchanged;
  - `rx_overrun` ← 1 and `dropped_words` += 1.

**Emit stage**
- Each edge with `pending`≠0 emits the lowest set channel i: `hs` = `hold_i`, and bit i of `pending` is cleared.
- If `half_valid`=0: `acc_lo` ← `hs`, `half_valid` ← 1.
- If `half_valid`=1: `fifo_data` ← {`hs`, `acc_lo`} and `half_valid` ← 0.
  - If `fifo_full`=0 on that edge: `fifo_wrreq` ← 1.
  - Otherwise: `fifo_wrreq` ← 0, `rx_overrun` ← 1, `dropped_words` += 1 (the word is lost).
- `fifo_wrreq` is 0 on every edge that does not complete a word.

**Odd channel counts**
- With an odd number of enabled channels, the trailing half-word stays in `acc_lo`. It pairs with the first half-word of the next accepted strobe, so the stream is continuous across strobes and carries no padding.
- A change of `channels` does not flush `acc_lo`.

**Status**
- `clear_status` clears `rx_overrun` and zeroes `dropped_words`.
- If a loss event occurs on the same edge as `clear_status`, the loss wins: `rx_overrun`=1 and `dropped_words`=1.
- `dropped_words` holds at 16'hFFFF once it saturates.

**Reset**
- Values: `pending`=0, `half_valid`=0, `acc_lo`=0, hold registers 0, `fifo_data`=0, `fifo_wrreq`=0, `rx_overrun`=0, `dropped_words`=0.
- Reset mid-operation abandons any partially emitted strobe and any residual half-word. Nothing is written.
- `reset` has priority over every other input.

## Timing
- `rxstrobe` high in cycle N, accepted:
  - first channel emitted on the edge ending cycle N+1;
  - k-th enabled channel emitted on the edge ending cycle N+k.
- With `half_valid`=0 at acceptance: `fifo_wrreq` is high in cycle N+3 (2nd half-word) and N+5 (4th half-word).
- `fifo_full` is sampled on the edge that completes the word, i.e. its value in cycle N+2 for the first word.
- Sustained throughput: an accepted strobe every P cycles, where P = number of enabled channels. Faster strobes are rejected as overrun.
- `fifo_wrreq` is never high for two consecutive cycles. It is a registered output with no combinational path from the inputs.

## Test plan
- Reset, then `channels`=4'b0011, `ch_0`=16'h1111, `ch_1`=16'h2222, strobe in cycle N -> `fifo_wrreq` high only in N+3 with `fifo_data`=32'h2222_1111; `rx_overrun`=0.
- `channels`=4'b1111, ch0..3 = 16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3, strobes every 4 cycles for 8 strobes -> 16 words, alternating 32'hB1B1_A0A0 / 32'hD3D3_C2C2; no overrun.
- `channels`=4'b0100, `ch_2` = 16'h0001, 16'h0002, 16'h0003 on three strobes -> words 32'h0002_0001 only; `half_valid`=1 holding 16'h0003.
- `channels`=4'b1111, second strobe 2 cycles after the first -> second strobe rejected: `rx_overrun`=1, `dropped_words`=1, exactly 2 words written; then `clear_status` -> both cleared.
- `fifo_full`=1 held through a 4-channel strobe -> no `fifo_wrreq`, `dropped_words`=2, `rx_overrun`=1; release `fifo_full` -> next strobe writes normally.
- `reset` asserted on the cycle after a 4-channel strobe -> no writes, all outputs 0; the next strobe after reset produces correctly paired words starting from `half_valid`=0.

Source files
------------

// File: rtl/rx_sample_packer_if.sv
// Write-side bundle between the rx sample packer and the rx FIFO.
// The packer drives data/request; the FIFO returns its full flag.
interface rx_sample_packer_if;
   logic [31:0] fifo_data;
   logic        fifo_wrreq;
   logic        fifo_full;

   modport master (
      output fifo_data,
      output fifo_wrreq,
      input  fifo_full
   );

   modport slave (
      input  fifo_data,
      input  fifo_wrreq,
      output fifo_full
   );
endinterface

// File: rtl/rx_sample_packer.sv
// Captures enabled channel samples per strobe, serializes them into
// half-words and packs pairs into 32-bit FIFO words with loss tracking.
module rx_sample_packer (
   input  logic                        rx_clk,
   input  logic                        reset,
   input  logic                        clear_status,
   input  logic [3:0]                  channels,
   input  logic [15:0]                 ch_0,
   input  logic [15:0]                 ch_1,
   input  logic [15:0]                 ch_2,
   input  logic [15:0]                 ch_3,
   input  logic                        rxstrobe,
   rx_sample_packer_if.master          fifo,
   output logic                        rx_overrun,
   output logic [15:0]                 dropped_words,
   output logic [15:0]                 debug_bus
);

   logic [15:0] hold_q [4];
   logic [15:0] hold_d [4];
   logic [3:0]  pending_q, pending_d;
   logic [15:0] acc_lo_q, acc_lo_d;
   logic        half_valid_q, half_valid_d;
   logic [31:0] fifo_data_q, fifo_data_d;
   logic        fifo_wrreq_q, fifo_wrreq_d;
   logic        overrun_q, overrun_d;
   logic [15:0] dropped_q, dropped_d;

   logic [1:0]  sel;
   logic [15:0] hs;
   logic [3:0]  pend_clr;
   logic        any_pend;
   logic        one_left;
   logic        strobe_v;
   logic        accept;
   logic        reject;
   logic        lost_word;
   logic [1:0]  loss_cnt;
   logic [15:0] drop_base;
   logic [16:0] drop_sum;

   // lowest set pending bit wins: scan high to low, last hit sticks
   always_comb begin
      sel = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (pending_q[i]) sel = i[1:0];
      end
   end

   assign hs        = hold_q[sel];
   assign pend_clr  = pending_q & ~(4'b0001 << sel);
   assign any_pend  = |pending_q;
   assign one_left  = any_pend &&
                      ((pending_q & (pending_q - 4'd1)) == 4'd0);
   assign strobe_v  = rxstrobe && (|channels);
   assign accept    = strobe_v && (!any_pend || one_left);
   assign reject    = strobe_v && !accept;
   assign lost_word = any_pend && half_valid_q && fifo.fifo_full;
   assign loss_cnt  = {1'b0, reject} + {1'b0, lost_word};
   assign drop_base = clear_status ? 16'd0 : dropped_q;
   assign drop_sum  = {1'b0, drop_base} + {15'd0, loss_cnt};

   always_comb begin
      pending_d    = accept ? channels : pend_clr;
      hold_d       = hold_q;
      acc_lo_d     = acc_lo_q;
      half_valid_d = half_valid_q;
      fifo_data_d  = fifo_data_q;
      fifo_wrreq_d = 1'b0;
      if (accept) begin
         hold_d[0] = ch_0;
         hold_d[1] = ch_1;
         hold_d[2] = ch_2;
         hold_d[3] = ch_3;
      end
      if (any_pend) begin
         if (!half_valid_q) begin
            acc_lo_d     = hs;
            half_valid_d = 1'b1;
         end else begin
            fifo_data_d  = {hs, acc_lo_q};
            half_valid_d = 1'b0;
            fifo_wrreq_d = !fifo.fifo_full;
         end
      end
      // a loss on the clearing edge still leaves its mark
      overrun_d = (loss_cnt != 2'd0) || (overrun_q && !clear_status);
      dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge rx_clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) hold_q[i] <= 16'd0;
         pending_q    <= 4'd0;
         acc_lo_q     <= 16'd0;
         half_valid_q <= 1'b0;
         fifo_data_q  <= 32'd0;
         fifo_wrreq_q <= 1'b0;
         overrun_q    <= 1'b0;
         dropped_q    <= 16'd0;
      end else begin
         for (int i = 0; i < 4; i++) hold_q[i] <= hold_d[i];
         pending_q    <= pending_d;
         acc_lo_q     <= acc_lo_d;
         half_valid_q <= half_valid_d;
         fifo_data_q  <= fifo_data_d;
         fifo_wrreq_q <= fifo_wrreq_d;
         overrun_q    <= overrun_d;
         dropped_q    <= dropped_d;
      end
   end

   assign fifo.fifo_data  = fifo_data_q;
   assign fifo.fifo_wrreq = fifo_wrreq_q;
   assign rx_overrun      = overrun_q;
   assign dropped_words   = dropped_q;
   assign debug_bus       = {pending_q, half_valid_q, fifo_wrreq_q,
                             fifo.fifo_full, overrun_q, dropped_q[7:0]};

endmodule

// File: tb/tb_rx_sample_packer.sv
// Bench for rx_sample_packer: queue-based stream model checked every
// cycle, plus directed scenarios with literal expected words.
module tb_rx_sample_packer;

   logic        rx_clk = 1'b0;
   logic        reset;
   logic        clear_status;
   logic [3:0]  channels;
   logic [15:0] ch_0, ch_1, ch_2, ch_3;
   logic        rxstrobe;
   logic        fifo_full;
   logic        rx_overrun;
   logic [15:0] dropped_words;
   logic [15:0] debug_bus;

   rx_sample_packer_if fif ();
   assign fif.fifo_full = fifo_full;

   rx_sample_packer dut (
      .rx_clk        (rx_clk),
      .reset         (reset),
      .clear_status  (clear_status),
      .channels      (channels),
      .ch_0          (ch_0),
      .ch_1          (ch_1),
      .ch_2          (ch_2),
      .ch_3          (ch_3),
      .rxstrobe      (rxstrobe),
      .fifo          (fif.master),
      .rx_overrun    (rx_overrun),
      .dropped_words (dropped_words),
      .debug_bus     (debug_bus)
   );

   always #5 rx_clk = ~rx_clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit armed = 1'b0;

   always @(posedge rx_clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   // model: queue of {channel, sample} still to emit, plus a half-word slot
   logic [17:0] mq [$];
   logic [15:0] m_acc;
   logic        m_hv;
   logic [31:0] m_data;
   logic        m_wr;
   logic        m_ovr;
   logic [15:0] m_drop;

   always @(posedge rx_clk) begin : model
      int          ev;
      int          n;
      int          tot;
      logic [17:0] e;
      logic [15:0] chv [4];
      if (reset) begin
         mq.delete();
         m_acc  = 16'd0;
         m_hv   = 1'b0;
         m_data = 32'd0;
         m_wr   = 1'b0;
         m_ovr  = 1'b0;
         m_drop = 16'd0;
      end else begin
         chv  = '{ch_0, ch_1, ch_2, ch_3};
         ev   = 0;
         m_wr = 1'b0;
         n    = mq.size();
         if (n > 0) begin
            e = mq.pop_front();
            if (!m_hv) begin
               m_acc = e[15:0];
               m_hv  = 1'b1;
            end else begin
               m_data = {e[15:0], m_acc};
               m_hv   = 1'b0;
               if (fifo_full) ev++;
               else m_wr = 1'b1;
            end
         end
         if (rxstrobe && channels != 4'd0) begin
            if (n <= 1) begin
               for (int i = 0; i < 4; i++)
                  if (channels[i]) mq.push_back({i[1:0], chv[i]});
            end else begin
               ev++;
            end
         end
         tot    = (clear_status ? 0 : int'(m_drop)) + ev;
         m_drop = (tot > 65535) ? 16'hFFFF : tot[15:0];
         m_ovr  = (ev > 0) ? 1'b1 : (m_ovr && !clear_status);
      end
   end

   logic [31:0] wlog [$];
   int          wcyc [$];

   always @(negedge rx_clk) begin : compare
      logic [3:0] pm;
      if (armed) begin
         pm = 4'd0;
         foreach (mq[i]) pm = pm | (4'b0001 << mq[i][17:16]);
         chk("wrreq", {31'd0, fif.fifo_wrreq}, {31'd0, m_wr});
         chk("data", fif.fifo_data, m_data);
         chk("overrun", {31'd0, rx_overrun}, {31'd0, m_ovr});
         chk("dropped", {16'd0, dropped_words}, {16'd0, m_drop});
         chk("debug", {16'd0, debug_bus},
             {16'd0, pm, m_hv, m_wr, fifo_full, m_ovr, m_drop[7:0]});
         if (fif.fifo_wrreq) begin
            wlog.push_back(fif.fifo_data);
            wcyc.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge rx_clk);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic do_strobe(logic [3:0] m, logic [15:0] a, logic [15:0] b,
                            logic [15:0] c, logic [15:0] d);
      channels = m;
      ch_0     = a;
      ch_1     = b;
      ch_2     = c;
      ch_3     = d;
      rxstrobe = 1'b1;
      tick();
      rxstrobe = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wlog.delete();
      wcyc.delete();
   endtask

   function automatic logic [31:0] wat(int i);
      return (i < wlog.size()) ? wlog[i] : 32'hDEAD_BEEF;
   endfunction

   int n0;

   initial begin
      reset        = 1'b1;
      clear_status = 1'b0;
      channels     = 4'd0;
      ch_0         = 16'd0;
      ch_1         = 16'd0;
      ch_2         = 16'd0;
      ch_3         = 16'd0;
      rxstrobe     = 1'b0;
      fifo_full    = 1'b0;
      tick();
      armed = 1'b1;
      do_reset();
      chk("rst_data", fif.fifo_data, 32'd0);
      chk("rst_wrreq", {31'd0, fif.fifo_wrreq}, 32'd0);
      chk("rst_ovr", {31'd0, rx_overrun}, 32'd0);
      chk("rst_drop", {16'd0, dropped_words}, 32'd0);
      chk("rst_debug", {16'd0, debug_bus}, 32'd0);

      n0 = cyc;
      do_strobe(4'b0011, 16'h1111, 16'h2222, 16'h0, 16'h0);
      idle(6);
      chk("t1_count", wlog.size(), 32'd1);
      chk("t1_word", wat(0), 32'h2222_1111);
      chk("t1_lat", (wcyc.size() > 0) ? wcyc[0] - n0 : -1, 32'd3);
      chk("t1_ovr", {31'd0, rx_overrun}, 32'd0);

      do_reset();
      for (int s = 0; s < 8; s++) begin
         do_strobe(4'b1111, 16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3);
         idle(3);
      end
      idle(6);
      chk("t2_count", wlog.size(), 32'd16);
      for (int i = 0; i < 16; i++)
         chk("t2_word", wat(i), i[0] ? 32'hD3D3_C2C2 : 32'hB1B1_A0A0);
      chk("t2_ovr", {31'd0, rx_overrun}, 32'd0);

      do_reset();
      for (int v = 1; v <= 3; v++) begin
         do_strobe(4'b0100, 16'h0, 16'h0, v[15:0], 16'h0);
         idle(2);
      end
      idle(2);
      chk("t3_count", wlog.size(), 32'd1);
      chk("t3_word", wat(0), 32'h0002_0001);
      chk("t3_half", {31'd0, debug_bus[11]}, 32'd1);
      do_strobe(4'b0100, 16'h0, 16'h0, 16'h0004, 16'h0);
      idle(3);
      chk("t3_carry", wat(1), 32'h0004_0003);

      do_reset();
      do_strobe(4'b1111, 16'h1, 16'h2, 16'h3, 16'h4);
      idle(1);
      do_strobe(4'b1111, 16'h5, 16'h6, 16'h7, 16'h8);
      idle(8);
      chk("t4_ovr", {31'd0, rx_overrun}, 32'd1);
      chk("t4_drop", {16'd0, dropped_words}, 32'd1);
      chk("t4_count", wlog.size(), 32'd2);
      chk("t4_w0", wat(0), 32'h0002_0001);
      chk("t4_w1", wat(1), 32'h0004_0003);
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      chk("t4_clr_ovr", {31'd0, rx_overrun}, 32'd0);
      chk("t4_clr_drop", {16'd0, dropped_words}, 32'd0);

      do_reset();
      fifo_full = 1'b1;
      do_strobe(4'b1111, 16'h1, 16'h2, 16'h3, 16'h4);
      idle(8);
      chk("t5_count", wlog.size(), 32'd0);
      chk("t5_drop", {16'd0, dropped_words}, 32'd2);
      chk("t5_ovr", {31'd0, rx_overrun}, 32'd1);
      fifo_full = 1'b0;
      do_strobe(4'b1111, 16'h9, 16'hA, 16'hB, 16'hC);
      idle(8);
      chk("t5_count2", wlog.size(), 32'd2);
      chk("t5_w0", wat(0), 32'h000A_0009);
      chk("t5_w1", wat(1), 32'h000C_000B);

      do_reset();
      do_strobe(4'b1111, 16'h1, 16'h2, 16'h3, 16'h4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_data", fif.fifo_data, 32'd0);
      chk("t6_wrreq", {31'd0, fif.fifo_wrreq}, 32'd0);
      chk("t6_debug", {16'd0, debug_bus}, 32'd0);
      idle(6);
      chk("t6_nowr", wlog.size(), 32'd0);
      do_strobe(4'b1111, 16'h5, 16'h6, 16'h7, 16'h8);
      idle(8);
      chk("t6_count", wlog.size(), 32'd2);
      chk("t6_w0", wat(0), 32'h0006_0005);
      chk("t6_w1", wat(1), 32'h0008_0007);

      do_reset();
      for (int k = 0; k < 4000; k++) begin
         rxstrobe     = ($urandom_range(0, 2) == 0);
         channels     = 4'($urandom);
         ch_0         = 16'($urandom);
         ch_1         = 16'($urandom);
         ch_2         = 16'($urandom);
         ch_3         = 16'($urandom);
         fifo_full    = ($urandom_range(0, 7) == 0);
         clear_status = ($urandom_range(0, 31) == 0);
         reset        = ($urandom_range(0, 499) == 0);
         tick();
      end
      rxstrobe     = 1'b0;
      fifo_full    = 1'b0;
      clear_status = 1'b0;
      reset        = 1'b0;
      idle(8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
